// File: rtl/rs_pkg.sv
// Shared RS(68,64) definitions used by the message gatherer and its neighbours.
// Carries the code geometry, symbol/length types and the gatherer state encoding.
package rs_pkg;

  localparam int RS_K     = 64;
  localparam int RS_N     = 68;
  localparam int RS_SYM_W = 8;

  typedef logic [RS_SYM_W-1:0] rs_sym_t;
  typedef logic [6:0]          rs_len_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } gather_state_e;

  // Snapshot of the gatherer's internal control state, for observation only.
  typedef struct packed {
    gather_state_e state;
    rs_len_t       count;
    rs_len_t       held_len;
  } gather_dbg_t;

endpackage

// File: rtl/rs_msg_gatherer.sv
// Byte-serial to parallel front end for the RS(68,64) encoder.
// Collects one symbol per cycle into a gather buffer and hands a complete message
// to an output register with a valid/ready handshake.
// Optional feature macro: RS_SHORTEN_EN (s_last closes a frame early; msg_len = bytes seen).
//
// Handshakes: a beat happens on a rising edge where valid and ready are both high.
// The producer holds data stable while valid is high and not yet accepted. s_ready is
// a registered output and never depends combinationally on s_valid or msg_ready.
// msg_valid stays high, with msg_out/msg_len unchanged, until msg_ready is seen.
module rs_msg_gatherer
  import rs_pkg::*;
#(
  parameter int K     = RS_K,
  parameter int SYM_W = RS_SYM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [SYM_W-1:0] msg_out [K],
  output rs_len_t          msg_len,
  output logic             msg_valid,
  input  logic             msg_ready,
  output gather_dbg_t      dbg
);

  localparam int               IDX_W    = $clog2(K);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);
  localparam rs_len_t          FULL_LEN = rs_len_t'(K);

  gather_state_e    state;
  gather_state_e    state_nx;
  logic [IDX_W-1:0] count;
  rs_len_t          held_len;
  logic [SYM_W-1:0] gbuf [K];

  logic    in_beat;
  logic    out_free;
  logic    close_beat;
  rs_len_t close_len;
  logic    load_fill;
  logic    load_full;
  logic    go_full;

`ifndef RS_SHORTEN_EN
  // Frames are always full length, so the frame marker carries no information.
  logic unused_last;
  assign unused_last = s_last;
`endif

  // Beat decode: which beat closes a frame and where the finished message goes.
  always_comb begin
    in_beat  = s_valid && s_ready;
    out_free = !msg_valid || msg_ready;
`ifdef RS_SHORTEN_EN
    close_beat = in_beat && ((count == LAST_IDX) || s_last);
    close_len  = rs_len_t'(count) + 7'd1;
`else
    close_beat = in_beat && (count == LAST_IDX);
    close_len  = FULL_LEN;
`endif
    load_fill = (state == FILL) && close_beat && out_free;
    go_full   = (state == FILL) && close_beat && !out_free;
    load_full = (state == FULL) && out_free;
    state_nx  = state;
    if (go_full) begin
      state_nx = FULL;
    end else if (load_full) begin
      state_nx = FILL;
    end
  end

  // Gather/output FSM: fills the buffer, moves finished frames into msg_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      held_len  <= '0;
      s_ready   <= 1'b0;
      msg_valid <= 1'b0;
      msg_len   <= '0;
      for (int i = 0; i < K; i++) begin
        gbuf[i]    <= '0;
        msg_out[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      // Ready follows the state we are about to be in, so it stays registered.
      s_ready <= (state_nx == FILL);

      if (in_beat) begin
        gbuf[count] <= s_data;
        count       <= close_beat ? '0 : count + IDX_W'(1);
      end

      if (go_full) begin
        held_len <= close_len;
      end

      if (load_fill) begin
        // Closing byte bypasses the buffer; slots past the frame read as zero.
        for (int i = 0; i < K; i++) begin
          if (i < int'(count)) begin
            msg_out[i] <= gbuf[i];
          end else if (i == int'(count)) begin
            msg_out[i] <= s_data;
          end else begin
            msg_out[i] <= '0;
          end
        end
        msg_len   <= close_len;
        msg_valid <= 1'b1;
      end else if (load_full) begin
        // Whole frame already sits in the buffer; mask stale bytes beyond its length.
        for (int i = 0; i < K; i++) begin
          msg_out[i] <= (i < int'(held_len)) ? gbuf[i] : '0;
        end
        msg_len   <= held_len;
        msg_valid <= 1'b1;
      end else if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end
    end
  end

  assign dbg = {state, rs_len_t'(count), held_len};

endmodule
